// File: rtl/prbs31_lock_checker.sv
`default_nettype none
// prbs31_lock_checker: self-synchronising PRBS31 (out[n]=out[n-28]^out[n-31]) checker with saturating BER counters.
// Optional LOCKED-state error-window resync when PRBS_CHK_RESYNC_EN is defined.  Rev 1.0
module prbs31_lock_checker #(
  parameter int LOCK_COUNT = 64,
  parameter int CNT_W      = 32,
  parameter int WINDOW     = 1024,
  parameter int ERR_THRESH = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             data_in,
  input  logic             data_in_valid,
  input  logic             clear,
  output logic             locked,
  output logic [1:0]       state,
  output logic             err_pulse,
  output logic [CNT_W-1:0] total_bits,
  output logic [CNT_W-1:0] total_bit_errors,
  output logic [CNT_W-1:0] resync_count
);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam logic [MATCH_W-1:0] LOCK_LAST = MATCH_W'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'b00,
    ST_VERIFY  = 2'b01,
    ST_LOCKED  = 2'b10
  } state_t;

  if (LOCK_COUNT < 1 || CNT_W < 1 || WINDOW < 1 || ERR_THRESH < 1) begin : g_param_check
    $error("prbs31_lock_checker: all parameters must be >= 1");
  end

  state_t             state_q, state_d;
  logic [30:0]        hist_q, hist_d;
  logic [4:0]         fill_q, fill_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic               err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]   bits_q, bits_d;
  logic [CNT_W-1:0]   errs_q, errs_d;

  logic predicted;
  logic mismatch;
  logic resync;

  assign predicted = hist_q[27] ^ hist_q[30];
  assign mismatch  = data_in ^ predicted;

`ifdef PRBS_CHK_RESYNC_EN
  localparam int WB_W = $clog2(WINDOW + 1);
  localparam int WE_W = $clog2(ERR_THRESH + 1);

  logic [WB_W-1:0]  win_bits_q, win_bits_d;
  logic [WE_W-1:0]  win_errs_q, win_errs_d;
  logic [CNT_W-1:0] resync_cnt_q, resync_cnt_d;

  // Window bookkeeping; clear beats both the window restart and a pending resync.
  always_comb begin
    win_bits_d   = win_bits_q;
    win_errs_d   = win_errs_q;
    resync_cnt_d = resync_cnt_q;
    resync       = 1'b0;
    if (clear) begin
      win_bits_d   = '0;
      win_errs_d   = '0;
      resync_cnt_d = '0;
    end else if (state_q == ST_LOCKED && data_in_valid) begin
      if (win_errs_q + WE_W'(mismatch) == WE_W'(ERR_THRESH)) begin
        resync     = 1'b1;
        win_bits_d = '0;
        win_errs_d = '0;
        if (resync_cnt_q != '1) begin
          resync_cnt_d = resync_cnt_q + CNT_W'(1);
        end
      end else if (win_bits_q + WB_W'(1) == WB_W'(WINDOW)) begin
        win_bits_d = '0;
        win_errs_d = '0;
      end else begin
        win_bits_d = win_bits_q + WB_W'(1);
        win_errs_d = win_errs_q + WE_W'(mismatch);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      win_bits_q   <= '0;
      win_errs_q   <= '0;
      resync_cnt_q <= '0;
    end else begin
      win_bits_q   <= win_bits_d;
      win_errs_q   <= win_errs_d;
      resync_cnt_q <= resync_cnt_d;
    end
  end

  assign resync_count = resync_cnt_q;
`else
  assign resync       = 1'b0;
  assign resync_count = '0;
`endif

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    match_d     = match_q;
    err_pulse_d = 1'b0;
    bits_d      = bits_q;
    errs_d      = errs_q;

    if (data_in_valid) begin
      case (state_q)
        ST_ACQUIRE: begin
          hist_d = {hist_q[29:0], data_in};
          fill_d = fill_q + 5'd1;
          if (fill_q == 5'd30) begin
            state_d = ST_VERIFY;
            match_d = '0;
          end
        end
        ST_VERIFY: begin
          hist_d = {hist_q[29:0], data_in};
          if (mismatch) begin
            match_d = '0;
          end else if (match_q == LOCK_LAST) begin
            // An all-zero history predicts 0 forever; refuse to lock onto it.
            if (hist_q != 31'd0) begin
              state_d = ST_LOCKED;
              match_d = match_q + MATCH_W'(1);
            end
          end else begin
            match_d = match_q + MATCH_W'(1);
          end
        end
        ST_LOCKED: begin
          // Feeding back the prediction keeps a channel error from echoing at taps 28/31.
          hist_d      = {hist_q[29:0], predicted};
          err_pulse_d = mismatch;
          if (!clear) begin
            if (bits_q != '1) begin
              bits_d = bits_q + CNT_W'(1);
            end
            if (mismatch && errs_q != '1) begin
              errs_d = errs_q + CNT_W'(1);
            end
          end
          if (resync) begin
            state_d = ST_ACQUIRE;
            hist_d  = '0;
            fill_d  = '0;
            match_d = '0;
          end
        end
        default: begin
          state_d = ST_ACQUIRE;
          hist_d  = '0;
          fill_d  = '0;
          match_d = '0;
        end
      endcase
    end

    if (clear) begin
      bits_d = '0;
      errs_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_ACQUIRE;
      hist_q      <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      err_pulse_q <= 1'b0;
      bits_q      <= '0;
      errs_q      <= '0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      err_pulse_q <= err_pulse_d;
      bits_q      <= bits_d;
      errs_q      <= errs_d;
    end
  end

  assign locked           = (state_q == ST_LOCKED);
  assign state            = state_q;
  assign err_pulse        = err_pulse_q;
  assign total_bits       = bits_q;
  assign total_bit_errors = errs_q;

endmodule
`default_nettype wire
